wb_bram_arbiter: RTL

WB_BRAM_ARBITER -- requirements
Module: wb_bram_arbiter

---
 rtl/wb_bram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wb_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port between a Wishbone slave and an engine port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with a fixed DELAYS-cycle access latency.
module wb_bram_arbiter #(
    parameter int unsigned DELAYS  = 10,
    parameter logic [7:0]  WB_BASE = 8'h38
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        eng_req_i,
    input  logic [3:0]  eng_we_i,
    input  logic [31:0] eng_adr_i,
    input  logic [31:0] eng_dat_i,
    output logic        eng_gnt_o,
    output logic        eng_ack_o,
    output logic [31:0] eng_dat_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_a_o,
    output logic [31:0] bram_di_o,
    input  logic [31:0] bram_do_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [4:0] LAST_CNT = 5'(DELAYS - 1);

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic        last_wb_reg;
    logic        owner_eng_reg;
    logic        abandon_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;
    logic [3:0]  we_reg;
    logic [31:0] wbs_dat_reg;
    logic [31:0] eng_dat_reg;

    logic        wb_live;
    logic        wb_req;
    logic        any_req;
    logic        grant_wb;
    logic [3:0]  wb_we;
    logic        unused_adr;

    assign wb_live    = wbs_stb_i & wbs_cyc_i;
    assign wb_req     = wb_live & (wbs_adr_i[31:24] == WB_BASE);
    assign any_req    = wb_req | eng_req_i;
    // Wishbone wins unless both ask and Wishbone had the previous grant.
    assign grant_wb   = wb_req & (~eng_req_i | ~last_wb_reg);
    assign unused_adr = &{1'b0, eng_adr_i[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wb_we
            assign wb_we[gi] = wbs_we_i & wbs_sel_i[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == LAST_CNT) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= 5'd0;
            last_wb_reg   <= 1'b0;
            owner_eng_reg <= 1'b0;
            abandon_reg   <= 1'b0;
            adr_reg       <= 32'd0;
            dat_reg       <= 32'd0;
            we_reg        <= 4'd0;
            wbs_dat_reg   <= 32'd0;
            eng_dat_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        cnt_reg       <= 5'd1;
                        owner_eng_reg <= ~grant_wb;
                        last_wb_reg   <= grant_wb;
                        abandon_reg   <= 1'b0;
                        if (grant_wb) begin
                            adr_reg <= {8'd0, wbs_adr_i[23:0]};
                            dat_reg <= wbs_dat_i;
                            we_reg  <= wb_we;
                        end else begin
                            adr_reg <= {8'd0, eng_adr_i[23:0]};
                            dat_reg <= eng_dat_i;
                            we_reg  <= eng_we_i;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    // Capture read data on the edge into RESP so it is valid during the ack cycle.
                    if (cnt_reg == LAST_CNT) begin
                        if (owner_eng_reg) eng_dat_reg <= bram_do_i;
                        else               wbs_dat_reg <= bram_do_i;
                    end
                end
                default: ;
            endcase
            // A Wishbone master that walks away still lets the access finish, just unacked.
            if ((state_reg != IDLE) && !owner_eng_reg && !wb_live) abandon_reg <= 1'b1;
        end
    end

    assign bram_en_o = (state_reg != IDLE);
    assign bram_we_o = (state_reg == ISSUE) ? we_reg : 4'd0;
    assign bram_a_o  = adr_reg;
    assign bram_di_o = dat_reg;
    assign eng_gnt_o = (state_reg == ISSUE) & owner_eng_reg;
    assign eng_ack_o = (state_reg == RESP) & owner_eng_reg;
    assign wbs_ack_o = (state_reg == RESP) & ~owner_eng_reg & ~abandon_reg & wb_live;
    assign wbs_dat_o = wbs_dat_reg;
    assign eng_dat_o = eng_dat_reg;

endmodule
